// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM demodulator: measures high time and period per frame, flags a dead link.
module pwm_capture #(
    parameter int CNT_WIDTH   = 12,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 4095
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pwm_in,
    output logic [CNT_WIDTH-1:0] duty,
    output logic [CNT_WIDTH-1:0] period,
    output logic                 sample_valid,
    output logic                 timeout,
    output logic                 stuck_high,
    output logic                 stuck_low
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] TO_VAL = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_d_q;
    logic [CNT_WIDTH-1:0]   period_cnt_q, period_cnt_d;
    logic [CNT_WIDTH-1:0]   high_cnt_q, high_cnt_d;
    logic [CNT_WIDTH-1:0]   duty_q, duty_d;
    logic [CNT_WIDTH-1:0]   period_q, period_d;
    logic                   emit_q, emit_d;
    logic                   sample_valid_q, sample_valid_d;
    logic                   timeout_q, timeout_d;
    logic                   to_done_q, to_done_d;
    logic                   stuck_high_q, stuck_high_d;
    logic                   stuck_low_q, stuck_low_d;

    logic s;
    logic rise;
    logic fall;
    logic period_sat;

    assign s          = sync_q[SYNC_STAGES-1];
    assign rise       = s & ~s_d_q;
    assign fall       = ~s & s_d_q;
    assign period_sat = (period_cnt_q == TO_VAL);

    always_comb begin
        sync_d         = {sync_q[SYNC_STAGES-2:0], pwm_in};
        state_d        = state_q;
        period_cnt_d   = period_cnt_q;
        high_cnt_d     = high_cnt_q;
        duty_d         = duty_q;
        period_d       = period_q;
        emit_d         = 1'b0;
        sample_valid_d = emit_q;
        timeout_d      = 1'b0;
        to_done_d      = to_done_q;
        stuck_high_d   = stuck_high_q;
        stuck_low_d    = stuck_low_q;

        if (rise) begin
            // A rise in HIGH means a one-cycle low was merged away, so it closes a frame too.
            state_d      = HIGH;
            period_cnt_d = ONE;
            high_cnt_d   = ONE;
            to_done_d    = 1'b0;
            stuck_high_d = 1'b0;
            stuck_low_d  = 1'b0;
            if (state_q != IDLE) begin
                duty_d   = high_cnt_q;
                period_d = period_cnt_q;
                emit_d   = 1'b1;
            end
        end else begin
            if (!period_sat) begin
                period_cnt_d = period_cnt_q + ONE;
            end
            if (state_q == HIGH && !fall && high_cnt_q != TO_VAL) begin
                high_cnt_d = high_cnt_q + ONE;
            end
            if (state_q == HIGH && fall) begin
                state_d = LOW;
            end
            // Fire once on arrival at the limit; to_done_q suppresses repeats while saturated.
            if (period_sat && !to_done_q) begin
                state_d      = IDLE;
                timeout_d    = 1'b1;
                to_done_d    = 1'b1;
                stuck_high_d = s;
                stuck_low_d  = ~s;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            sync_q         <= '0;
            s_d_q          <= 1'b0;
            period_cnt_q   <= '0;
            high_cnt_q     <= '0;
            duty_q         <= '0;
            period_q       <= '0;
            emit_q         <= 1'b0;
            sample_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            to_done_q      <= 1'b0;
            stuck_high_q   <= 1'b0;
            stuck_low_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync_q         <= sync_d;
            s_d_q          <= s;
            period_cnt_q   <= period_cnt_d;
            high_cnt_q     <= high_cnt_d;
            duty_q         <= duty_d;
            period_q       <= period_d;
            emit_q         <= emit_d;
            sample_valid_q <= sample_valid_d;
            timeout_q      <= timeout_d;
            to_done_q      <= to_done_d;
            stuck_high_q   <= stuck_high_d;
            stuck_low_q    <= stuck_low_d;
        end
    end

    assign duty         = duty_q;
    assign period       = period_q;
    assign sample_valid = sample_valid_q;
    assign timeout      = timeout_q;
    assign stuck_high   = stuck_high_q;
    assign stuck_low    = stuck_low_q;

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- PWM demodulator: the receive end of the PWM audio link driven by pwm_music.
- Synchronises an external PWM input into the 39.75 MHz core clock domain.
- Measures high time and period of each PWM frame in clock cycles, emitting one sample per frame with a single-cycle valid strobe.
- Detects a dead link (stuck high or stuck low) and flags it. Used as a loopback checker and as a capture front-end for audio analysis.

Parameters:
- CNT_WIDTH, 12, width of the duty, period and internal counters.
- SYNC_STAGES, 2, number of input synchroniser flops; legal range 2..4.
- TIMEOUT, 4095, cycles without a rising edge before the link is declared dead. Must be <= 2^CNT_WIDTH-1 and >= 2.

Ports:
- clk  input  1  core clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset, synchronous deassertion handled upstream.
- pwm_in  input  1  asynchronous PWM input.
- duty  output  CNT_WIDTH  high time of the last complete frame, in cycles.
- period  output  CNT_WIDTH  rise-to-rise time of the last complete frame, in cycles.
- sample_valid  output  1  one-cycle pulse when duty/period update.
- timeout  output  1  one-cycle pulse when TIMEOUT is reached.
- stuck_high  output  1  level; link dead with input high.
- stuck_low  output  1  level; link dead with input low.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, synchroniser flops 0, counters 0, state IDLE.
- Synchroniser: pwm_in passes through SYNC_STAGES flops giving s. A delay flop gives s_d.
  - rise = s & ~s_d; fall = ~s & s_d.
  - A rise is detected SYNC_STAGES+1 clk edges after pwm_in is first sampled high.
- No glitch filter: any synchronised pulse, even 1 cycle wide, is a valid edge.
- States:
  - IDLE: waiting for the first rise; the partial frame after reset or timeout is discarded. On rise -> HIGH.
  - HIGH: on fall -> LOW; on rise (only possible after a 1-cycle low that the synchroniser merged away) treat as in LOW.
  - LOW: on rise -> HIGH and emit sample.
- Counters, on the rise cycle in any state:
  - period_cnt := 1, high_cnt := 1.
  - If the state was LOW (or HIGH per the rule above): duty := high_cnt, period := period_cnt, sample_valid := 1 next cycle (registered).
- Counters, otherwise:
  - period_cnt increments each cycle, saturating at TIMEOUT.
  - high_cnt increments only in HIGH when fall is not asserted, and is frozen from the fall cycle.
- Result: for a clean input, period equals the exact input period and duty the exact high time in clk cycles. Latency from the input rising edge to sample_valid is SYNC_STAGES+2 cycles.
- duty and period hold their values between samples; they are only valid when sample_valid is seen.
- Timeout: when period_cnt == TIMEOUT and rise is not asserted that cycle:
  - state -> IDLE.
  - timeout pulses for 1 cycle, only on the first arrival at TIMEOUT; no repeat while saturated.
  - stuck_high := s and stuck_low := ~s, registered.
  - duty and period are not modified and no sample_valid is emitted.
- This applies in IDLE too: a constant input from reset raises stuck_* TIMEOUT cycles after reset.
- stuck_high and stuck_low clear on the next rise, which also starts a fresh frame from IDLE; no sample for that frame's predecessor.
- Simultaneous rise and period_cnt==TIMEOUT: the rise wins, the sample is emitted with period=TIMEOUT, and there is no timeout.
- 0% duty (constant low) and 100% duty (constant high) are reported only via timeout and the stuck_* flags.
- Reset mid-frame: everything clears immediately; the first frame after reset is discarded.

Test Plan:
- Defaults, PWM period 100, high 25, 10 frames -> first frame discarded, then 9 sample_valid pulses 100 cycles apart, each with duty=25, period=100; first pulse SYNC_STAGES+2 cycles after the 2nd input rise.
- Period 256, high sweeping 1..255 with 1-cycle-wide highs included -> duty tracks exactly 1..255, period=256 on every sample.
- Input held high 5000 cycles after a valid frame -> timeout pulses once at 4095 cycles after the last rise, stuck_high=1, stuck_low=0, duty/period unchanged. A new frame (period 100, high 25) then clears the flag on its rise, and the next sample is duty=25, period=100.
- Input low from reset -> timeout pulse once at cycle 4095 after reset, stuck_low=1, no sample_valid ever.
- Frame with period exactly 4095 -> sample duty correct, period=4095, no timeout pulse.
- rst_n asserted mid-frame at cycle 40 of a 100-cycle frame -> all outputs 0 immediately; after release the next frame is discarded and the one after it is reported correctly.
